// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronised frame capture with error checking,
// optional E0/F0 prefix folding, and a scancode FIFO for the consumer.
module ps2_kbd_rx_fifo #(
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000,
  parameter int DECODE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             nextdata_n,
  input  logic             clr_err,
  output logic [7:0]       data,
  output logic             ext,
  output logic             brk,
  output logic             ready,
  output logic             overflow,
  output logic             parity_err,
  output logic             frame_err,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] cs_q, ds_q;
  logic                   prev_q;
  logic                   clk_s, bit_in, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= '1;
      ds_q   <= '1;
      prev_q <= 1'b1;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], ps2_clk};
      ds_q   <= {ds_q[SYNC_STAGES-2:0], ps2_data};
      prev_q <= clk_s;
    end
  end

  assign clk_s  = cs_q[SYNC_STAGES-1];
  assign bit_in = ds_q[SYNC_STAGES-1];
  assign fall   = prev_q & ~clk_s;

  state_t          state_q, state_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [10:0]     sh_q, sh_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            push, par_set, frm_set;
  logic [9:0]      entry;
  logic [7:0]      rx_byte;
  logic            start_ok, stop_ok, par_ok;

  // Frame bits shift in at the top; after 11 falls sh_q[0] is the start bit.
  assign rx_byte  = sh_q[8:1];
  assign start_ok = ~sh_q[0];
  assign stop_ok  = sh_q[10];
  assign par_ok   = ^sh_q[9:1];

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    tmo_d    = tmo_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    push     = 1'b0;
    par_set  = 1'b0;
    frm_set  = 1'b0;
    entry    = (DECODE != 0) ? {ext_q, brk_q, rx_byte}
                             : {2'b00, rx_byte};
    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (fall) begin
          sh_d     = {bit_in, sh_q[10:1]};
          bitcnt_d = 4'd1;
          state_d  = S_RECV;
        end
      end
      S_RECV: begin
        if (fall) begin
          sh_d     = {bit_in, sh_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tmo_d    = '0;
          if (bitcnt_q == 4'd10) state_d = S_CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          frm_set  = 1'b1;
          bitcnt_d = '0;
          tmo_d    = '0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        bitcnt_d = '0;
        state_d  = S_IDLE;
        if (start_ok && stop_ok && par_ok) begin
          if (DECODE != 0 && rx_byte == 8'hE0) begin
            ext_d = 1'b1;
          end else if (DECODE != 0 && rx_byte == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end else begin
          par_set = ~par_ok;
          frm_set = ~start_ok | ~stop_ok;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      tmo_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      tmo_q    <= tmo_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, perr_q, ferr_q;
  logic               pop, full, wr, ovf_set;

  assign pop     = ~nextdata_n & (cnt_q != '0);
  assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q  <= cnt_d;
      ovf_q  <= clr_err ? 1'b0 : (ovf_q | ovf_set);
      perr_q <= clr_err ? 1'b0 : (perr_q | par_set);
      ferr_q <= clr_err ? 1'b0 : (ferr_q | frm_set);
    end
  end

  assign ready            = (cnt_q != '0);
  assign {ext, brk, data} = ready ? mem[rptr_q] : 10'd0;
  assign overflow         = ovf_q;
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;
  assign count            = cnt_q;

endmodule
